// File: rtl/calc_pkg.sv
// Shared encodings for the multiport calculator: command codes, response codes, port FSM states.
// Rotate commands only decode as valid when CALC_ROTATE_EN is defined.
package calc_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6,
    CMD_ROL = 4'd9,
    CMD_ROR = 4'd10
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_OVF  = 2'd2,
    RESP_INV  = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OP2,
    ST_PEND,
    ST_RESP
  } port_state_e;

  localparam int CMD_W  = 4;
  localparam int RESP_W = 2;

endpackage

// File: rtl/calc_multiport_engine_if.sv
// Request/response bus of the multiport calculator: per-port command/operand in, response/result out.
interface calc_multiport_engine_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32
);
  logic [NUM_PORTS*4-1:0]      cmd_in;
  logic [NUM_PORTS*DATA_W-1:0] data_in;
  logic [NUM_PORTS*2-1:0]      out_resp;
  logic [NUM_PORTS*DATA_W-1:0] out_data;

  modport master (output cmd_in, output data_in, input out_resp, input out_data);
  modport slave  (input cmd_in, input data_in, output out_resp, output out_data);
endinterface

// File: rtl/calc_port.sv
// One request port: captures cmd/op1 then op2, waits for a grant, and presents the response for one cycle.
module calc_port
  import calc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [3:0]        cmd_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              grant_i,
  input  resp_e             alu_resp_i,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              pend_o,
  output logic [3:0]        cmd_o,
  output logic [DATA_W-1:0] op1_o,
  output logic [DATA_W-1:0] op2_o,
  output resp_e             resp_o,
  output logic [DATA_W-1:0] data_o
);

  port_state_e       state_q;
  resp_e             resp_q;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        cmd_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      resp_q  <= RESP_NONE;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          resp_q <= RESP_NONE;
          data_q <= '0;
          if (cmd_i != CMD_NOP) state_q <= ST_OP2;
        end
        ST_OP2:  state_q <= ST_PEND;
        ST_PEND: begin
          if (grant_i) begin
            state_q <= ST_RESP;
            resp_q  <= alu_resp_i;
            data_q  <= alu_data_i;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          resp_q  <= RESP_NONE;
          data_q  <= '0;
        end
      endcase
    end
  end

  // Operand holding registers carry no reset: they are only read while PEND.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_IDLE && cmd_i != CMD_NOP) begin
      cmd_q <= cmd_i;
      op1_q <= data_i;
    end
    if (state_q == ST_OP2) op2_q <= data_i;
  end

  assign pend_o = (state_q == ST_PEND);
  assign cmd_o  = cmd_q;
  assign op1_o  = op1_q;
  assign op2_o  = op2_q;
  assign resp_o = resp_q;
  assign data_o = data_q;

endmodule

// File: rtl/calc_multiport_engine.sv
// Multiport calculator top: round-robin arbiter feeding one shared ALU whose result lands in the granted port.
// Optional feature macro: CALC_ROTATE_EN enables rotate-left (cmd 9) and rotate-right (cmd 10).
module calc_multiport_engine
  import calc_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int SHAMT_W   = $clog2(DATA_W)
) (
  input logic                    c_clk,
  input logic                    reset_n,
  calc_multiport_engine_if.slave bus
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] pend;
  logic [NUM_PORTS-1:0] gnt;
  logic [3:0]           cmd_p [NUM_PORTS];
  logic [DATA_W-1:0]    op1_p [NUM_PORTS];
  logic [DATA_W-1:0]    op2_p [NUM_PORTS];

  logic [PTR_W-1:0]  ptr_q, ptr_d, sel;
  logic              found;
  logic [3:0]        alu_cmd;
  logic [DATA_W-1:0] alu_op1, alu_op2, alu_data;
  logic [DATA_W:0]   sum;
  logic [SHAMT_W-1:0] shamt;
  resp_e             alu_resp;
`ifdef CALC_ROTATE_EN
  logic [2*DATA_W-1:0] dbl;
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    calc_port #(.DATA_W(DATA_W)) u_port (
      .clk_i      (c_clk),
      .rst_ni     (reset_n),
      .cmd_i      (bus.cmd_in[4*p +: 4]),
      .data_i     (bus.data_in[DATA_W*p +: DATA_W]),
      .grant_i    (gnt[p]),
      .alu_resp_i (alu_resp),
      .alu_data_i (alu_data),
      .pend_o     (pend[p]),
      .cmd_o      (cmd_p[p]),
      .op1_o      (op1_p[p]),
      .op2_o      (op2_p[p]),
      .resp_o     (bus.out_resp[2*p +: 2]),
      .data_o     (bus.out_data[DATA_W*p +: DATA_W])
    );
  end

  // First pass searches from the pointer upward, second pass wraps to the low indices.
  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    sel     = '0;
    alu_cmd = '0;
    alu_op1 = '0;
    alu_op2 = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!found && pend[j] && PTR_W'(j) >= ptr_q) begin
        found = 1'b1; gnt[j] = 1'b1; sel = PTR_W'(j);
        alu_cmd = cmd_p[j]; alu_op1 = op1_p[j]; alu_op2 = op2_p[j];
      end
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!found && pend[j]) begin
        found = 1'b1; gnt[j] = 1'b1; sel = PTR_W'(j);
        alu_cmd = cmd_p[j]; alu_op1 = op1_p[j]; alu_op2 = op2_p[j];
      end
    end
    ptr_d = ptr_q;
    if (found) ptr_d = (int'(sel) == NUM_PORTS - 1) ? '0 : sel + PTR_W'(1);
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  always_comb begin
    alu_resp = RESP_INV;
    alu_data = '0;
    shamt    = alu_op2[SHAMT_W-1:0];
    sum      = {1'b0, alu_op1} + {1'b0, alu_op2};
`ifdef CALC_ROTATE_EN
    dbl      = '0;
`endif
    case (alu_cmd)
      CMD_ADD: begin
        alu_resp = sum[DATA_W] ? RESP_OVF : RESP_OK;
        alu_data = sum[DATA_W] ? '0 : sum[DATA_W-1:0];
      end
      CMD_SUB: begin
        alu_resp = (alu_op2 > alu_op1) ? RESP_OVF : RESP_OK;
        alu_data = (alu_op2 > alu_op1) ? '0 : alu_op1 - alu_op2;
      end
      CMD_SHL: begin
        alu_resp = RESP_OK;
        alu_data = alu_op1 << shamt;
      end
      CMD_SHR: begin
        alu_resp = RESP_OK;
        alu_data = alu_op1 >> shamt;
      end
`ifdef CALC_ROTATE_EN
      CMD_ROL: begin
        dbl      = {alu_op1, alu_op1} << shamt;
        alu_resp = RESP_OK;
        alu_data = dbl[2*DATA_W-1:DATA_W];
      end
      CMD_ROR: begin
        dbl      = {alu_op1, alu_op1} >> shamt;
        alu_resp = RESP_OK;
        alu_data = dbl[DATA_W-1:0];
      end
`endif
      default: begin
        alu_resp = RESP_INV;
        alu_data = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_calc_multiport_engine.sv
// Directed scoreboard bench for calc_multiport_engine (4 ports, 32-bit); honours CALC_ROTATE_EN.
module tb_calc_multiport_engine;
  import calc_pkg::*;

  localparam int NP = 4;
  localparam int DW = 32;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [NP][$];
  exp_t mon_e;

  calc_multiport_engine_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

  calc_multiport_engine #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
    .c_clk   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input int p, input logic [1:0] r, input logic [31:0] d, input int c);
    exp_t e;
    e.resp = r;
    e.data = d;
    e.cyc  = c;
    sb[p].push_back(e);
  endtask

  // Uncontended transaction: cmd+op1 now, op2 next cycle, response in cycle T+3.
  task automatic single(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] er, input logic [31:0] ed);
    expect_resp(p, er, ed, cyc + 3);
    bus.cmd_in[4*p +: 4]    = c;
    bus.data_in[DW*p +: DW] = a;
    tick();
    bus.cmd_in[4*p +: 4]    = 4'd0;
    bus.data_in[DW*p +: DW] = b;
    tick();
    bus.data_in[DW*p +: DW] = '0;
    tick();
    tick();
  endtask

  task automatic contend_all();
    int t0;
    t0 = cyc;
    for (int p = 0; p < NP; p++) begin
      expect_resp(p, RESP_OK, 32'(2 * (p + 1)), t0 + 3 + p);
      bus.cmd_in[4*p +: 4]    = CMD_ADD;
      bus.data_in[DW*p +: DW] = 32'(p + 1);
    end
    tick();
    bus.cmd_in = '0;
    tick();
    bus.data_in = '0;
    repeat (5) tick();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < NP; p++) begin
        if (bus.out_resp[2*p +: 2] != 2'd0) begin
          chk($sformatf("p%0d_resp_expected", p), 64'(sb[p].size() != 0), 64'd1);
          if (sb[p].size() != 0) begin
            mon_e = sb[p].pop_front();
            chk($sformatf("p%0d_resp", p), 64'(bus.out_resp[2*p +: 2]), 64'(mon_e.resp));
            chk($sformatf("p%0d_data", p), 64'(bus.out_data[DW*p +: DW]), 64'(mon_e.data));
            chk($sformatf("p%0d_cycle", p), 64'(cyc), 64'(mon_e.cyc));
          end
        end
      end
    end
  end

  initial begin
    logic [1:0]  rot_r;
    logic [31:0] rol_d, ror_d;
    bus.cmd_in  = '0;
    bus.data_in = '0;
    repeat (2) tick();
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("rst_p%0d_resp", p), 64'(bus.out_resp[2*p +: 2]), 64'd0);
      chk($sformatf("rst_p%0d_data", p), 64'(bus.out_data[DW*p +: DW]), 64'd0);
    end
    rst_n = 1'b1;
    tick();

    contend_all();
    contend_all();

    // Reset while ports 1 and 2 are still waiting for the ALU.
    for (int p = 0; p < 3; p++) begin
      bus.cmd_in[4*p +: 4]    = CMD_ADD;
      bus.data_in[DW*p +: DW] = 32'd1;
    end
    tick();
    bus.cmd_in = '0;
    tick();
    bus.data_in = '0;
    tick();
    chk("midrst_p0_resp_before", 64'(bus.out_resp[1:0]), 64'(RESP_OK));
    chk("midrst_p0_data_before", 64'(bus.out_data[31:0]), 64'd2);
    rst_n = 1'b0;
    #1;
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("midrst_p%0d_resp", p), 64'(bus.out_resp[2*p +: 2]), 64'd0);
      chk($sformatf("midrst_p%0d_data", p), 64'(bus.out_data[DW*p +: DW]), 64'd0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    single(0, CMD_ADD, 32'd2, 32'd2, RESP_OK, 32'd4);

    for (int k = 0; k < DW; k++)
      single(0, CMD_ADD, 32'd1 << k, 32'd0, RESP_OK, 32'd1 << k);

    single(0, CMD_ADD, 32'hFFFF_FFFF, 32'd1, RESP_OVF, 32'd0);
    single(1, CMD_SUB, 32'd3, 32'd5, RESP_OVF, 32'd0);
    single(2, CMD_SUB, 32'd5, 32'd3, RESP_OK, 32'd2);
    single(3, CMD_SUB, 32'd7, 32'd7, RESP_OK, 32'd0);
    single(1, CMD_SHL, 32'd1, 32'd33, RESP_OK, 32'd2);
    single(2, CMD_SHR, 32'h8000_0000, 32'd31, RESP_OK, 32'd1);
    single(3, 4'd3, 32'd1, 32'd1, RESP_INV, 32'd0);
    single(0, 4'd15, 32'd1, 32'd1, RESP_INV, 32'd0);
`ifdef CALC_ROTATE_EN
    rot_r = RESP_OK;
    rol_d = 32'h0000_0003;
    ror_d = 32'hC000_0000;
`else
    rot_r = RESP_INV;
    rol_d = 32'd0;
    ror_d = 32'd0;
`endif
    single(1, CMD_ROL, 32'h8000_0001, 32'd1, rot_r, rol_d);
    single(2, CMD_ROR, 32'h8000_0001, 32'd1, rot_r, ror_d);

    repeat (4) tick();
    for (int p = 0; p < NP; p++)
      chk($sformatf("p%0d_missing_responses", p), 64'(sb[p].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
